// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared core types: branch outcome, branch prediction record, queue depth
package mips_core_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int GHISTORY_WIDTH = 8;
    localparam int BIQ_DEPTH      = 8;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]     pc;
        logic [GHISTORY_WIDTH-1:0] ghistory;
        BranchOutcome              prediction;
        BranchOutcome              prediction_gshare;
        BranchOutcome              prediction_2bit;
        logic [ADDR_WIDTH-1:0]     recovery_target;
    } branch_pred_storage;

    localparam int BPS_W = $bits(branch_pred_storage);

endpackage

// File: rtl/branch_info_queue.sv
// rtl/branch_info_queue.sv - in-order FIFO of branch prediction records from decode to commit
module branch_info_queue
    import mips_core_pkg::*;
#(
    parameter int DEPTH = BIQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push_valid,
    input  logic [BPS_W-1:0]      i_push_data,
    output logic                  o_full,
    input  logic                  i_pop,
    input  logic                  i_pop_outcome,
    input  logic                  i_flush,
    output logic                  o_fb_valid,
    output logic [BPS_W-1:0]      o_fb_data,
    output logic                  o_mispredict,
    output logic [ADDR_WIDTH-1:0] o_recovery_target,
    output logic [PTR_W:0]        o_count,
    output logic                  o_underflow
);

    localparam int CNT_W = PTR_W + 1;

    // Record storage is not reset; occupancy is tracked only by count.
    logic [BPS_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             underflow;

    logic               empty;
    logic               full;
    logic               pop_ok;
    logic               push_ok;
    logic               mispredict;
    logic               clear;
    branch_pred_storage head_rec;

    // Occupancy flags and handshake qualification.
    always_comb begin
        empty      = (count == '0);
        full       = (count == CNT_W'(DEPTH));
        pop_ok     = i_pop & ~empty;
        // A full queue can still accept a record when the head leaves in the same cycle.
        push_ok    = i_push_valid & (~full | pop_ok);
        head_rec   = branch_pred_storage'(mem[head]);
        mispredict = pop_ok & (logic'(head_rec.prediction) != i_pop_outcome);
        // Either source of a clear discards every younger record, including a same-cycle push.
        clear      = i_flush | mispredict;
    end

    // Record write; wrong-path pushes during a clear are not stored.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[tail] <= i_push_data;
        end
    end

    // Pointer, occupancy and sticky underflow state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            if (i_pop && empty && !i_flush) begin
                underflow <= 1'b1;
            end
            if (clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push_ok) begin
                    tail <= tail + PTR_W'(1);
                end
                if (pop_ok) begin
                    head <= head + PTR_W'(1);
                end
                count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
            end
        end
    end

    // Head outputs come straight from registered state; no push bypass.
    always_comb begin
        o_full            = full;
        o_fb_valid        = ~empty;
        o_fb_data         = mem[head];
        o_mispredict      = mispredict;
        o_recovery_target = head_rec.recovery_target;
        o_count           = count;
        o_underflow       = underflow;
    end

endmodule

// File: tb/tb_branch_info_queue.sv
// tb/tb_branch_info_queue.sv - directed self-checking bench for branch_info_queue
module tb_branch_info_queue;
    import mips_core_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic                  i_push_valid;
    logic [BPS_W-1:0]      i_push_data;
    logic                  o_full;
    logic                  i_pop;
    logic                  i_pop_outcome;
    logic                  i_flush;
    logic                  o_fb_valid;
    logic [BPS_W-1:0]      o_fb_data;
    logic                  o_mispredict;
    logic [ADDR_WIDTH-1:0] o_recovery_target;
    logic [3:0]            o_count;
    logic                  o_underflow;

    branch_pred_storage fb;
    assign fb = branch_pred_storage'(o_fb_data);

    int errors = 0;
    int checks = 0;

    branch_info_queue dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_push_valid      (i_push_valid),
        .i_push_data       (i_push_data),
        .o_full            (o_full),
        .i_pop             (i_pop),
        .i_pop_outcome     (i_pop_outcome),
        .i_flush           (i_flush),
        .o_fb_valid        (o_fb_valid),
        .o_fb_data         (o_fb_data),
        .o_mispredict      (o_mispredict),
        .o_recovery_target (o_recovery_target),
        .o_count           (o_count),
        .o_underflow       (o_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BPS_W-1:0] make_rec(input logic [31:0] pc, input BranchOutcome pred);
        branch_pred_storage r;
        r.pc                = pc;
        r.ghistory          = pc[7:0];
        r.prediction        = pred;
        r.prediction_gshare = pred;
        r.prediction_2bit   = pred;
        r.recovery_target   = pc + 32'h1000;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_push_valid  = 1'b0;
        i_pop         = 1'b0;
        i_pop_outcome = 1'b0;
        i_flush       = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input BranchOutcome pred);
        i_push_valid = 1'b1;
        i_push_data  = make_rec(pc, pred);
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        i_push_data = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", o_full); end
        checks++; if (o_fb_valid !== 1'b0) begin errors++; $display("FAIL reset_fb_valid got=%b exp=0", o_fb_valid); end
        checks++; if (o_mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict got=%b exp=0", o_mispredict); end
        checks++; if (o_underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got=%b exp=0", o_underflow); end
    endtask

    task automatic test_single_push();
        push(32'h100, TAKEN);
        checks++; if (o_fb_valid !== 1'b1) begin errors++; $display("FAIL single_fb_valid got=%b exp=1", o_fb_valid); end
        checks++; if (fb.pc !== 32'h100) begin errors++; $display("FAIL single_pc got=%h exp=100", fb.pc); end
        checks++; if (o_count !== 4'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", o_count); end
        i_pop = 1'b1; i_pop_outcome = 1'b1;
        tick();
        idle();
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL single_pop_count got=%0d exp=0", o_count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            push(32'h100 + 32'(4 * i), TAKEN);
        end
        checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL full_flag got=%b exp=1", o_full); end
        push(32'h120, TAKEN);
        checks++; if (o_count !== 4'd8) begin errors++; $display("FAIL full_drop_count got=%0d exp=8", o_count); end
        checks++; if (fb.pc !== 32'h100) begin errors++; $display("FAIL full_drop_head got=%h exp=100", fb.pc); end
        i_push_valid = 1'b1; i_push_data = make_rec(32'h124, TAKEN);
        i_pop = 1'b1; i_pop_outcome = 1'b1;
        tick();
        idle();
        checks++; if (o_count !== 4'd8) begin errors++; $display("FAIL full_pushpop_count got=%0d exp=8", o_count); end
        checks++; if (fb.pc !== 32'h104) begin errors++; $display("FAIL full_pushpop_head got=%h exp=104", fb.pc); end
        // Drain through the oldest entries to confirm 0x124 landed behind 0x11C.
        for (int i = 0; i < 7; i++) begin
            i_pop = 1'b1; i_pop_outcome = 1'b1;
            tick();
        end
        idle();
        checks++; if (fb.pc !== 32'h124) begin errors++; $display("FAIL full_tail_entry got=%h exp=124", fb.pc); end
        i_flush = 1'b1;
        tick();
        idle();
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL full_flush_count got=%0d exp=0", o_count); end
    endtask

    task automatic test_mispredict();
        push(32'h300, TAKEN);
        push(32'h304, NOT_TAKEN);
        i_pop = 1'b1; i_pop_outcome = 1'b1;
        #1;
        checks++; if (o_mispredict !== 1'b0) begin errors++; $display("FAIL mp_correct got=%b exp=0", o_mispredict); end
        tick();
        idle();
        checks++; if (fb.pc !== 32'h304) begin errors++; $display("FAIL mp_head_adv got=%h exp=304", fb.pc); end
        checks++; if (o_count !== 4'd1) begin errors++; $display("FAIL mp_count1 got=%0d exp=1", o_count); end
        i_pop = 1'b1; i_pop_outcome = 1'b1;
        #1;
        checks++; if (o_mispredict !== 1'b1) begin errors++; $display("FAIL mp_flag got=%b exp=1", o_mispredict); end
        checks++; if (o_recovery_target !== 32'h1304) begin errors++; $display("FAIL mp_target got=%h exp=1304", o_recovery_target); end
        tick();
        idle();
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL mp_clear_count got=%0d exp=0", o_count); end
        checks++; if (o_fb_valid !== 1'b0) begin errors++; $display("FAIL mp_clear_valid got=%b exp=0", o_fb_valid); end
    endtask

    task automatic test_mispredict_push();
        push(32'h400, TAKEN);
        push(32'h404, TAKEN);
        i_pop = 1'b1; i_pop_outcome = 1'b0;
        i_push_valid = 1'b1; i_push_data = make_rec(32'h200, TAKEN);
        #1;
        checks++; if (o_mispredict !== 1'b1) begin errors++; $display("FAIL mpp_flag got=%b exp=1", o_mispredict); end
        tick();
        idle();
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL mpp_count got=%0d exp=0", o_count); end
        checks++; if (o_fb_valid !== 1'b0) begin errors++; $display("FAIL mpp_valid got=%b exp=0", o_fb_valid); end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 6; i++) begin
                push(32'h500 + 32'(r * 64) + 32'(4 * i), (i % 2 == 0) ? TAKEN : NOT_TAKEN);
            end
            checks++; if (o_count !== 4'd6) begin errors++; $display("FAIL wrap_fill%0d got=%0d exp=6", r, o_count); end
            for (int i = 0; i < 6; i++) begin
                i_pop = 1'b1; i_pop_outcome = (i % 2 == 0);
                #1;
                checks++;
                if (fb.pc !== 32'h500 + 32'(r * 64) + 32'(4 * i) || o_mispredict !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_order r%0d i%0d got=%h mp=%b exp=%h mp=0", r, i, fb.pc, o_mispredict,
                             32'h500 + 32'(r * 64) + 32'(4 * i));
                end
                tick();
            end
            idle();
            checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL wrap_drain%0d got=%0d exp=0", r, o_count); end
        end
    endtask

    task automatic test_underflow_flush_reset();
        i_pop = 1'b1; i_pop_outcome = 1'b1;
        tick();
        idle();
        checks++; if (o_underflow !== 1'b1) begin errors++; $display("FAIL uf_set got=%b exp=1", o_underflow); end
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL uf_count got=%0d exp=0", o_count); end
        push(32'h600, TAKEN);
        push(32'h604, TAKEN);
        push(32'h608, TAKEN);
        checks++; if (o_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got=%b exp=1", o_underflow); end
        checks++; if (o_count !== 4'd3) begin errors++; $display("FAIL flush_pre got=%0d exp=3", o_count); end
        i_flush = 1'b1; i_push_valid = 1'b1; i_push_data = make_rec(32'h60C, TAKEN);
        tick();
        idle();
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", o_count); end
        push(32'h700, TAKEN);
        push(32'h704, TAKEN);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", o_count); end
        checks++; if (o_fb_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", o_fb_valid); end
        checks++; if (o_underflow !== 1'b0) begin errors++; $display("FAIL rst_mid_underflow got=%b exp=0", o_underflow); end
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL rst_mid_full got=%b exp=0", o_full); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_full();
        test_mispredict();
        test_mispredict_push();
        test_wrap();
        test_underflow_flush_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
